// File: rtl/design_select_sequencer.sv
// Design select sequencer: drains all designs into reset, switches the I/O mux, then releases one design.
// Outputs registered; a switch takes DRAIN_CYCLES(+SETTLE_CYCLES) cycles, and req_ready is low while one runs.
module design_select_sequencer #(
  parameter int NUM_DESIGNS   = 12,
  parameter int SEL_W         = 4,
  parameter int DRAIN_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [SEL_W-1:0]       req_design,
  output logic                   req_ready,
  output logic [NUM_DESIGNS:1]   designs_cs,
  output logic [SEL_W-1:0]       active_sel,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int MAX_CYC = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [SEL_W-1:0] MAX_ID     = SEL_W'(NUM_DESIGNS);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SETTLE = 2'd2,
    ACTIVE = 2'd3
  } state_e;

  state_e                 state_q;
  logic [SEL_W-1:0]       target_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [NUM_DESIGNS:1]   cs_q;
  logic [SEL_W-1:0]       sel_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;
  logic [NUM_DESIGNS:1]   cs_release_d;
  logic                   req_invalid;

  assign req_ready   = (state_q == IDLE) || (state_q == ACTIVE);
  assign req_invalid = (req_design > MAX_ID);

  // Only the target's bit drops, so the mux and the released design always agree.
  always_comb begin
    cs_release_d = '1;
    for (int i = 1; i <= NUM_DESIGNS; i++) begin
      if (target_q == SEL_W'(i)) cs_release_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      cnt_q    <= '0;
      cs_q     <= '1;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE, ACTIVE: begin
          if (req_valid) begin
            state_q  <= DRAIN;
            target_q <= req_invalid ? '0 : req_design;
            err_q    <= req_invalid;
            cnt_q    <= '0;
            cs_q     <= '1;
            sel_q    <= '0;
            busy_q   <= 1'b1;
          end
        end
        DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            cnt_q <= '0;
            if (target_q == '0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= SETTLE;
              sel_q   <= target_q;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_q <= ACTIVE;
            cnt_q   <= '0;
            cs_q    <= cs_release_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign designs_cs = cs_q;
  assign active_sel = sel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
